// File: rtl/cv_lbarb_pkg.sv
// Shared constants and types for the line-buffer port arbiter: owner codes,
// linebuf port geometry, FSM state encoding and the bundled port type.
package cv_lbarb_pkg;

    localparam int unsigned LB_AW = 10;
    localparam int unsigned LB_DW = 64;
    localparam int unsigned LB_NB = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_BG   = 2'b01,
        OWN_SP   = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN_BG,
        ST_OWN_SP,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [LB_NB-1:0][LB_AW-1:0] rdaddr;
        logic                        ren;
        logic [LB_NB-1:0][LB_AW-1:0] wraddr;
        logic [LB_NB-1:0]            wen;
        logic [LB_DW-1:0]            wrdata;
    } lb_port_t;

    function automatic logic port_active(input lb_port_t p);
        return p.ren | (|p.wen);
    endfunction

endpackage

// File: rtl/cv_lbarb_mux.sv
// Combinational linebuf port select; during drain the read side is held off
// while writes from the releasing owner still pass through.
module cv_lbarb_mux
    import cv_lbarb_pkg::*;
(
    input  owner_e   sel,
    input  logic     rd_off,
    input  lb_port_t bg_port,
    input  lb_port_t sp_port,
    output lb_port_t lb_port
);

    always_comb begin
        lb_port = '0;
        case (sel)
            OWN_BG:  lb_port = bg_port;
            OWN_SP:  lb_port = sp_port;
            default: lb_port = '0;
        endcase
        if (rd_off) begin
            lb_port.ren    = 1'b0;
            lb_port.rdaddr = '0;
        end
    end

endmodule

// File: rtl/cv_lbarb.sv
// Line-buffer port arbiter: round-robin BG/SP ownership of the linebuf
// read-modify-write port with a post-release drain window.
module cv_lbarb
    import cv_lbarb_pkg::*;
#(
    parameter int unsigned DRAIN_CYC = 3  // 1..15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             line_start,
    input  logic             bg_req,
    input  logic             sp_req,
    output logic             bg_gnt,
    output logic             sp_gnt,
    input  logic [LB_AW-1:0] bg_rdaddr0,
    input  logic [LB_AW-1:0] bg_rdaddr1,
    input  logic [LB_AW-1:0] bg_rdaddr2,
    input  logic [LB_AW-1:0] bg_rdaddr3,
    input  logic [LB_AW-1:0] sp_rdaddr0,
    input  logic [LB_AW-1:0] sp_rdaddr1,
    input  logic [LB_AW-1:0] sp_rdaddr2,
    input  logic [LB_AW-1:0] sp_rdaddr3,
    input  logic             bg_ren,
    input  logic             sp_ren,
    input  logic [LB_AW-1:0] bg_wraddr0,
    input  logic [LB_AW-1:0] bg_wraddr1,
    input  logic [LB_AW-1:0] bg_wraddr2,
    input  logic [LB_AW-1:0] bg_wraddr3,
    input  logic [LB_AW-1:0] sp_wraddr0,
    input  logic [LB_AW-1:0] sp_wraddr1,
    input  logic [LB_AW-1:0] sp_wraddr2,
    input  logic [LB_AW-1:0] sp_wraddr3,
    input  logic             bg_wen0,
    input  logic             bg_wen1,
    input  logic             bg_wen2,
    input  logic             bg_wen3,
    input  logic             sp_wen0,
    input  logic             sp_wen1,
    input  logic             sp_wen2,
    input  logic             sp_wen3,
    input  logic [LB_DW-1:0] bg_wrdata,
    input  logic [LB_DW-1:0] sp_wrdata,
    output logic [LB_AW-1:0] l_rdaddr0,
    output logic [LB_AW-1:0] l_rdaddr1,
    output logic [LB_AW-1:0] l_rdaddr2,
    output logic [LB_AW-1:0] l_rdaddr3,
    output logic             l_ren,
    output logic [LB_AW-1:0] l_wraddr0,
    output logic [LB_AW-1:0] l_wraddr1,
    output logic [LB_AW-1:0] l_wraddr2,
    output logic [LB_AW-1:0] l_wraddr3,
    output logic             l_wen0,
    output logic             l_wen1,
    output logic             l_wen2,
    output logic             l_wen3,
    output logic [LB_DW-1:0] l_wrdata,
    output logic [1:0]       owner,
    output logic             busy,
    output logic             err,
    input  logic             clr_err,
    output logic [15:0]      wait_cnt
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [3:0]  drain_q, drain_d;
    logic        last_sp_q, last_sp_d;
    logic        bg_gnt_q, bg_gnt_d;
    logic        sp_gnt_q, sp_gnt_d;
    logic        err_q, err_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    lb_port_t bg_port, sp_port, lb_port;
    logic     arb_en, bg_first, pick_bg, pick_sp;
    logic     bg_act, sp_act, proto_err, wait_now;

    always_comb begin
        bg_port.rdaddr = {bg_rdaddr3, bg_rdaddr2, bg_rdaddr1, bg_rdaddr0};
        bg_port.ren    = bg_ren;
        bg_port.wraddr = {bg_wraddr3, bg_wraddr2, bg_wraddr1, bg_wraddr0};
        bg_port.wen    = {bg_wen3, bg_wen2, bg_wen1, bg_wen0};
        bg_port.wrdata = bg_wrdata;
        sp_port.rdaddr = {sp_rdaddr3, sp_rdaddr2, sp_rdaddr1, sp_rdaddr0};
        sp_port.ren    = sp_ren;
        sp_port.wraddr = {sp_wraddr3, sp_wraddr2, sp_wraddr1, sp_wraddr0};
        sp_port.wen    = {sp_wen3, sp_wen2, sp_wen1, sp_wen0};
        sp_port.wrdata = sp_wrdata;
    end

    // The last drain cycle arbitrates like IDLE, so the earliest new grant
    // lands DRAIN_CYC+1 edges after the release edge.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        drain_d   = drain_q;
        bg_gnt_d  = bg_gnt_q;
        sp_gnt_d  = sp_gnt_q;
        bg_first  = last_sp_q | line_start;
        last_sp_d = last_sp_q | line_start;
        arb_en    = 1'b0;
        pick_bg   = 1'b0;
        pick_sp   = 1'b0;

        case (state_q)
            ST_IDLE: arb_en = 1'b1;
            ST_OWN_BG: begin
                if (!bg_req) begin
                    state_d  = ST_DRAIN;
                    bg_gnt_d = 1'b0;
                    drain_d  = DRAIN_LOAD;
                end
            end
            ST_OWN_SP: begin
                if (!sp_req) begin
                    state_d  = ST_DRAIN;
                    sp_gnt_d = 1'b0;
                    drain_d  = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) arb_en = 1'b1;
                else               drain_d = drain_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (arb_en) begin
            pick_bg = bg_req & (~sp_req | bg_first);
            pick_sp = sp_req & ~pick_bg;
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            if (pick_bg) begin
                state_d   = ST_OWN_BG;
                owner_d   = OWN_BG;
                bg_gnt_d  = 1'b1;
                last_sp_d = 1'b0;
            end else if (pick_sp) begin
                state_d   = ST_OWN_SP;
                owner_d   = OWN_SP;
                sp_gnt_d  = 1'b1;
                last_sp_d = 1'b1;
            end
        end
    end

    // Drain tolerates the releasing owner's writes but not its reads.
    always_comb begin
        bg_act    = port_active(bg_port);
        sp_act    = port_active(sp_port);
        proto_err = 1'b0;
        case (state_q)
            ST_IDLE:   proto_err = bg_act | sp_act;
            ST_OWN_BG: proto_err = sp_act;
            ST_OWN_SP: proto_err = bg_act;
            default:   proto_err = (owner_q == OWN_BG) ? (sp_act | bg_ren)
                                                        : (bg_act | sp_ren);
        endcase
        err_d = proto_err | (err_q & ~clr_err);

        wait_now = (bg_req & ~bg_gnt_q) | (sp_req & ~sp_gnt_q);
        if (line_start)
            wait_cnt_d = {15'd0, wait_now};
        else if (wait_now && wait_cnt_q != '1)
            wait_cnt_d = wait_cnt_q + 16'd1;
        else
            wait_cnt_d = wait_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            drain_q    <= '0;
            last_sp_q  <= 1'b1;
            bg_gnt_q   <= 1'b0;
            sp_gnt_q   <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            drain_q    <= drain_d;
            last_sp_q  <= last_sp_d;
            bg_gnt_q   <= bg_gnt_d;
            sp_gnt_q   <= sp_gnt_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    cv_lbarb_mux u_mux (
        .sel     (owner_q),
        .rd_off  (state_q == ST_DRAIN),
        .bg_port (bg_port),
        .sp_port (sp_port),
        .lb_port (lb_port)
    );

    assign bg_gnt    = bg_gnt_q;
    assign sp_gnt    = sp_gnt_q;
    assign owner     = owner_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign wait_cnt  = wait_cnt_q;

    assign l_rdaddr0 = lb_port.rdaddr[0];
    assign l_rdaddr1 = lb_port.rdaddr[1];
    assign l_rdaddr2 = lb_port.rdaddr[2];
    assign l_rdaddr3 = lb_port.rdaddr[3];
    assign l_ren     = lb_port.ren;
    assign l_wraddr0 = lb_port.wraddr[0];
    assign l_wraddr1 = lb_port.wraddr[1];
    assign l_wraddr2 = lb_port.wraddr[2];
    assign l_wraddr3 = lb_port.wraddr[3];
    assign l_wen0    = lb_port.wen[0];
    assign l_wen1    = lb_port.wen[1];
    assign l_wen2    = lb_port.wen[2];
    assign l_wen3    = lb_port.wen[3];
    assign l_wrdata  = lb_port.wrdata;

endmodule

// File: doc/cv_lbarb.md
# cv_lbarb

Line-buffer port arbiter for the scanline renderer. It replaces the static BG/sprite multiplexer in front of `cv_linebuf`, sharing the single read-modify-write port between `cv_bgrender` and `cv_sp` through a req/gnt handshake. It applies round-robin fairness with a BG-first policy at each line start. After every release it holds the write path for a drain window, so that in-flight read-modify-write writes from the releasing renderer land before the next owner reads.

## Interface

Parameters:
- `DRAIN_CYC`, default 3: cycles the write path stays with the releasing owner after release. Must be ≥ linebuf read latency + renderer write-back depth. Range 1..15.

Ports:
- `clk` in 1: pixel-domain clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `line_start` in 1: one-cycle pulse at the start of each scanline's render window.
- `bg_req`, `sp_req` in 1 each: request to own the port, held for the whole burst.
- `bg_gnt`, `sp_gnt` out 1 each: grant, registered.
- `bg_rdaddr0..3`, `sp_rdaddr0..3` in 10 each: read addresses.
- `bg_ren`, `sp_ren` in 1 each: read enables.
- `bg_wraddr0..3`, `sp_wraddr0..3` in 10 each: write addresses.
- `bg_wen0..3`, `sp_wen0..3` in 1 each: write enables.
- `bg_wrdata`, `sp_wrdata` in 64 each: write data.
- `l_rdaddr0..3` out 10, `l_ren` out 1, `l_wraddr0..3` out 10, `l_wen0..3` out 1, `l_wrdata` out 64: muxed port to `cv_linebuf`.
- `owner` out 2: 00 none, 01 BG, 10 SP.
- `busy` out 1: state ≠ IDLE.
- `err` out 1: sticky protocol-error flag.
- `clr_err` in 1: clears `err`.
- `wait_cnt` out 16: count of cycles in which a requester was waiting. Cleared on `line_start`, saturates at 0xFFFF.

## Operation

- States: IDLE, OWN_BG, OWN_SP, DRAIN.
- IDLE, exactly one request: go to the matching OWN state and assert that gnt.
- IDLE, both requesting: grant the requester not served last. `last_sp` is a flag, set when SP is granted and cleared on BG grant.
- `line_start` forces `last_sp`=1, so BG wins the first contention of each line.
- OWN_x, `x_req` high: stay in OWN_x.
- OWN_x, `x_req` low: go to DRAIN, drop gnt, load the drain counter with DRAIN_CYC−1.
- DRAIN: `owner` keeps the previous owner's code. `l_wen*`, `l_wraddr*` and `l_wrdata` still come from the previous owner. `l_ren` is forced to 0 and `l_rdaddr*` to 0.
- DRAIN, counter at 0: go to IDLE. No grant is issued during DRAIN.
- Output mux:
  - Select comes from the registered owner and is combinational to the `l_*` outputs.
  - With no owner, all `l_*` outputs are 0.
  - Signals from the non-owner are ignored.
- Protocol error (sets `err`):
  - Any `wen` or `ren` from a requester that is not the current owner.
  - Exception: the previous owner's `wen` during DRAIN is legal.
  - `clr_err` and a new error in the same cycle: `err` stays 1.
- `wait_cnt` increments once per cycle in which `(bg_req & ~bg_gnt) | (sp_req & ~sp_gnt)`. If `line_start` and a wait occur in the same cycle, the result is 1.
- `line_start` does not abort an active grant or drain. Only the fairness flag and `wait_cnt` are affected.

## Timing

- Reset values: state IDLE; `bg_gnt`, `sp_gnt`, `busy`, `err` 0; `owner` 00; `wait_cnt` 0; `last_sp` 1; all `l_*` outputs 0.
- Grant latency: req sampled high in IDLE → gnt high on the next edge (1 cycle).
- Port handover:
  - The requester drives the port in the cycle gnt is first seen high.
  - `l_*` reflect that owner from the same edge that raises gnt.
- Release: req low at edge N → gnt low at N+1. DRAIN covers cycles N+1..N+DRAIN_CYC. Earliest new gnt is at N+DRAIN_CYC+1.
- `l_rddata` is not muxed. It fans out to both renderers unchanged.
- If a requester re-raises req while its own DRAIN is in progress, it competes normally in IDLE after the drain completes.
- Reset assertion mid-burst: all outputs go to reset values asynchronously; an in-flight write is lost. Deassertion is synchronised by the existing reset tree.

## Structure

- Shared package constants: owner codes (OWN_NONE, OWN_BG, OWN_SP), linebuf widths (addr 10, data 64), and the state encoding.
- One sub-module, `cv_lbarb_mux`: a purely combinational port select with force-read-off, instantiated once.
- The FSM, drain counter, fairness flag, error flag and `wait_cnt` live in `cv_lbarb`.

## Test plan

- BG-only burst:
  - Stimulus: `bg_req` for 10 cycles with `bg_wen0`=1 and `bg_wraddr0`=0x155.
  - Required: `bg_gnt` 1 cycle after req. `l_wraddr0`=0x155 while owned. DRAIN lasts 3 cycles with `l_ren`=0. `busy` drops at release+4.
- Simultaneous request after `line_start`:
  - Stimulus: both req high in IDLE.
  - Required: BG granted first. After BG releases and drains, SP granted. `wait_cnt` = BG burst length + DRAIN_CYC + 1.
- Round-robin:
  - Stimulus: both requesters issue repeated 4-cycle bursts, no `line_start`.
  - Required: grants alternate BG, SP, BG, SP.
- Drain write-through:
  - Stimulus: BG asserts `bg_wen1`=1 with `bg_wrdata`=0xDEADBEEF_00000001 two cycles after releasing req; SP requesting.
  - Required: the write appears on `l_*`. `sp_gnt` stays low until the drain ends.
- Protocol error:
  - Stimulus: `sp_ren`=1 while BG owns the port.
  - Required: `l_ren` follows BG only. `err`=1 next cycle and stays 1 until `clr_err`.
- Reset mid-burst:
  - Stimulus: `reset_n` low while OWN_SP.
  - Required: `sp_gnt`, `owner`, and all `l_*` outputs are 0 immediately. `wait_cnt`=0. After release, a BG-only req is granted in 1 cycle.
